// File: rtl/maze_read_arbiter.sv
// Two-port read arbiter in front of the single-bit maze memory: display normally wins,
// the player-input port is promoted after MAX_WAIT denied cycles. Fixed 3-cycle read latency.
module maze_read_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_gen_busy,
    input  logic                  i_disp_req,
    input  logic [ADDR_WIDTH-1:0] i_disp_addr,
    output logic                  o_disp_grant,
    output logic                  o_disp_valid,
    output logic                  o_disp_data,
    input  logic                  i_in_req,
    input  logic [ADDR_WIDTH-1:0] i_in_addr,
    output logic                  o_in_grant,
    output logic                  o_in_valid,
    output logic                  o_in_data,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_data,
    output logic                  o_disp_stall
);

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]            r_wait_cnt;
    logic                  r_vld_p1;
    logic                  r_own_p1;
    logic [ADDR_WIDTH-1:0] r_addr_p1;
    logic                  r_vld_p2;
    logic                  r_own_p2;
    logic                  r_disp_valid;
    logic                  r_disp_data;
    logic                  r_in_valid;
    logic                  r_in_data;
    logic                  r_disp_stall;

    logic w_wait_full;
    logic w_disp_grant;
    logic w_in_grant;
    logic w_xfer;

    assign w_wait_full  = (r_wait_cnt >= C_MAX_WAIT);
    assign w_disp_grant = !i_gen_busy && i_disp_req && (!i_in_req || !w_wait_full);
    assign w_in_grant   = !i_gen_busy && i_in_req && (!i_disp_req || w_wait_full);
    assign w_xfer       = w_disp_grant || w_in_grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt   <= '0;
            r_vld_p1     <= 1'b0;
            r_own_p1     <= 1'b0;
            r_addr_p1    <= '0;
            r_vld_p2     <= 1'b0;
            r_own_p2     <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= 1'b0;
            r_in_valid   <= 1'b0;
            r_in_data    <= 1'b0;
            r_disp_stall <= 1'b0;
        end else begin
            // Starvation counter freezes while the generator owns the memory
            if (!i_gen_busy) begin
                if (!i_in_req || w_in_grant) begin
                    r_wait_cnt <= '0;
                end else if (!w_wait_full) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end
            r_disp_stall <= i_disp_req && !w_disp_grant;

            // Stage p1: memory request, owner tag (1 = player input)
            r_vld_p1 <= w_xfer;
            r_own_p1 <= w_in_grant;
            if (w_xfer) begin
                r_addr_p1 <= w_in_grant ? i_in_addr : i_disp_addr;
            end

            // Stage p2: memory returns data during this stage
            r_vld_p2 <= r_vld_p1;
            r_own_p2 <= r_own_p1;

            // Stage p3: route sampled bit to its owner; the other port holds its data
            r_disp_valid <= r_vld_p2 && !r_own_p2;
            r_in_valid   <= r_vld_p2 && r_own_p2;
            if (r_vld_p2 && !r_own_p2) begin
                r_disp_data <= i_mem_data;
            end
            if (r_vld_p2 && r_own_p2) begin
                r_in_data <= i_mem_data;
            end
        end
    end

    assign o_disp_grant = w_disp_grant;
    assign o_in_grant   = w_in_grant;
    assign o_mem_en     = r_vld_p1;
    assign o_mem_addr   = r_addr_p1;
    assign o_disp_valid = r_disp_valid;
    assign o_disp_data  = r_disp_data;
    assign o_in_valid   = r_in_valid;
    assign o_in_data    = r_in_data;
    assign o_disp_stall = r_disp_stall;

endmodule

// File: tb/tb_maze_read_arbiter.sv
// Scoreboard bench for maze_read_arbiter: a behavioural memory answers reads, accepted
// transfers are queued with their owner, expected bit and due cycle, and checked on return.
module tb_maze_read_arbiter;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gen_busy = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          in_req = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic          mem_data = 1'b0;
    logic          o_disp_grant, o_disp_valid, o_disp_data;
    logic          o_in_grant, o_in_valid, o_in_data;
    logic          o_mem_en, o_disp_stall;
    logic [AW-1:0] o_mem_addr;

    maze_read_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_gen_busy(gen_busy),
        .i_disp_req(disp_req), .i_disp_addr(disp_addr),
        .o_disp_grant(o_disp_grant), .o_disp_valid(o_disp_valid), .o_disp_data(o_disp_data),
        .i_in_req(in_req), .i_in_addr(in_addr),
        .o_in_grant(o_in_grant), .o_in_valid(o_in_valid), .o_in_data(o_in_data),
        .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_data(mem_data),
        .o_disp_stall(o_disp_stall)
    );

    always #5 clk = ~clk;

    bit tb_mem [0:(1<<AW)-1];

    // Synchronous-read memory: data appears the cycle after mem_en
    always @(posedge clk) begin
        if (o_mem_en) mem_data <= tb_mem[o_mem_addr];
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        bit own;
        bit dat;
        int due;
    } sb_t;
    sb_t sb[$];

    // Monitor: samples mid-low-phase, after the driver has set this cycle's inputs
    initial begin
        int  cyc = 0;
        bit  exp_en = 0;
        int  exp_addr = 0;
        bit  exp_dd = 0;
        bit  exp_id = 0;
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                sb.delete();
                exp_en = 0; exp_addr = 0; exp_dd = 0; exp_id = 0;
            end else begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    check_eq("disp_valid", int'(o_disp_valid), int'(!e.own));
                    check_eq("in_valid", int'(o_in_valid), int'(e.own));
                    if (e.own) exp_id = e.dat;
                    else exp_dd = e.dat;
                end else begin
                    check_eq("disp_valid_idle", int'(o_disp_valid), 0);
                    check_eq("in_valid_idle", int'(o_in_valid), 0);
                end
                check_eq("disp_data", int'(o_disp_data), int'(exp_dd));
                check_eq("in_data", int'(o_in_data), int'(exp_id));
                check_eq("mem_en", int'(o_mem_en), int'(exp_en));
                check_eq("mem_addr", int'(o_mem_addr), exp_addr);
                check_eq("grant_excl", int'(o_disp_grant && o_in_grant), 0);
                exp_en = (disp_req && o_disp_grant) || (in_req && o_in_grant);
                if (in_req && o_in_grant) begin
                    exp_addr = int'(in_addr);
                    sb.push_back('{own: 1'b1, dat: tb_mem[in_addr], due: cyc + 3});
                end else if (disp_req && o_disp_grant) begin
                    exp_addr = int'(disp_addr);
                    sb.push_back('{own: 1'b0, dat: tb_mem[disp_addr], due: cyc + 3});
                end
            end
        end
    end

    bit stall_exp = 0;

    task automatic drive(input bit dr, input bit ir, input bit gb, input int da, input int ia,
                         input bit ed, input bit ei, input string tag);
        @(negedge clk);
        disp_req = dr; in_req = ir; gen_busy = gb;
        disp_addr = AW'(da); in_addr = AW'(ia);
        #1;
        check_eq({tag, "_dgrant"}, int'(o_disp_grant), int'(ed));
        check_eq({tag, "_igrant"}, int'(o_in_grant), int'(ei));
        check_eq({tag, "_stall"}, int'(o_disp_stall), int'(stall_exp));
        stall_exp = dr && !ed;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_mem_en"}, int'(o_mem_en), 0);
        check_eq({tag, "_mem_addr"}, int'(o_mem_addr), 0);
        check_eq({tag, "_dvalid"}, int'(o_disp_valid), 0);
        check_eq({tag, "_ivalid"}, int'(o_in_valid), 0);
        check_eq({tag, "_ddata"}, int'(o_disp_data), 0);
        check_eq({tag, "_idata"}, int'(o_in_data), 0);
        check_eq({tag, "_stall"}, int'(o_disp_stall), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) tb_mem[i] = 1'($urandom_range(0, 1));
        tb_mem[0] = 1; tb_mem[1] = 0; tb_mem[2] = 1; tb_mem[3] = 1;
        tb_mem[11'h07A] = 1;
        tb_mem[10] = 1; tb_mem[11] = 1;

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Input-only read of 0x07A
        drive(0, 1, 0, 0, 11'h07A, 0, 1, "inonly");
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0, "idle1");

        // Display streaming addresses 0..3
        for (int k = 0; k < 4; k++) drive(1, 0, 0, k, 0, 1, 0, "dstream");
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0, "idle2");

        // Both held: display wins four, input takes the fifth
        for (int k = 0; k < 10; k++)
            drive(1, 1, 0, 100 + k, 200 + k, (k % 5) != 4, (k % 5) == 4, "both");
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0, "idle3");

        // Two display wins, then generator busy; in-flight reads must still complete
        drive(1, 1, 0, 300, 400, 1, 0, "prebusy");
        drive(1, 1, 0, 301, 401, 1, 0, "prebusy");
        for (int k = 0; k < 6; k++) drive(1, 1, 1, 302, 402, 0, 0, "busy");
        drive(1, 1, 0, 303, 403, 1, 0, "postbusy");
        drive(1, 1, 0, 304, 404, 1, 0, "postbusy");
        drive(1, 1, 0, 305, 405, 0, 1, "postbusy");
        drive(1, 0, 0, 306, 0, 1, 0, "postbusy");
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0, "idle4");

        // Two accepts then reset while they are in flight
        drive(1, 0, 0, 10, 0, 1, 0, "prerst");
        drive(1, 0, 0, 11, 0, 1, 0, "prerst");
        @(negedge clk);
        rst_n = 1'b0; disp_req = 0; in_req = 0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1; disp_req = 1; disp_addr = AW'(3);
        #1;
        check_eq("postrst_dgrant", int'(o_disp_grant), 1);
        check_eq("postrst_stall", int'(o_disp_stall), 0);
        stall_exp = 0;
        repeat (6) drive(0, 0, 0, 0, 0, 0, 0, "idle5");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/maze_read_arbiter.md
MAZE_READ_ARBITER -- requirements
Module: maze_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, maze bit-memory address width.
REQ-002 Parameter MAX_WAIT, default 4, range 1..15, max consecutive denied cycles for input requester before forced win.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 gen_busy  input  1  maze generator owns memory; high blocks new grants.
REQ-006 disp_req  input  1  display read request (level).
REQ-007 disp_addr  input  ADDR_WIDTH  display read address, valid while disp_req high.
REQ-008 disp_grant  output  1  combinational accept for display.
REQ-009 disp_valid  output  1  registered one-cycle pulse, disp_data valid.
REQ-010 disp_data  output  1  returned maze bit for display.
REQ-011 in_req  input  1  player-input (collision check) read request (level).
REQ-012 in_addr  input  ADDR_WIDTH  player-input read address.
REQ-013 in_grant  output  1  combinational accept for player input.
REQ-014 in_valid  output  1  registered one-cycle pulse, in_data valid.
REQ-015 in_data  output  1  returned maze bit for player input.
REQ-016 mem_en  output  1  registered memory read enable.
REQ-017 mem_addr  output  ADDR_WIDTH  registered memory read address.
REQ-018 mem_data  input  1  memory read data, valid the cycle after mem_en.
REQ-019 disp_stall  output  1  registered pulse: display requested but not granted in previous cycle.

Function
REQ-020 Transfer occurs when req and grant are both high at a rising edge; requester may hold req high with a new address every cycle for back-to-back transfers.
REQ-021 At most one of disp_grant, in_grant high in any cycle.
REQ-022 gen_busy high: both grants low, irrespective of requests.
REQ-023 Only disp_req high: disp_grant=1; only in_req high: in_grant=1.
REQ-024 Both high, wait_cnt < MAX_WAIT: display wins; wait_cnt == MAX_WAIT: input wins.
REQ-025 wait_cnt (4-bit) increments, saturating at MAX_WAIT, each cycle in_req high, not granted, gen_busy low; clears to 0 when in_grant transfer occurs or in_req low; holds while gen_busy high.
REQ-026 Transfer at edge ending cycle C: mem_en=1, mem_addr=address in cycle C+1; mem_data sampled at end of C+2; owner's valid=1 and data=sampled bit in cycle C+3 (fixed 3-cycle latency).
REQ-027 Pipeline is fully pipelined: one transfer per cycle sustained, responses return in grant order, tagged to correct owner.
REQ-028 mem_en low and mem_addr holds previous value in cycles with no preceding transfer.
REQ-029 Non-owner valid stays 0 and non-owner data holds its last value when other requester's response returns.
REQ-030 gen_busy rising does not cancel in-flight reads; they complete with normal latency.
REQ-031 disp_stall=1 in cycle after any cycle with disp_req high and disp_grant low (including gen_busy block); else 0.

Reset
REQ-032 reset low: mem_en, disp_valid, in_valid, disp_stall, disp_data, in_data = 0; mem_addr = 0; wait_cnt = 0; pipeline owner tags cleared.
REQ-033 Reset asserted with reads in flight: no valid pulse produced for those reads after reset release.
REQ-034 First transfer possible at first rising edge after reset deasserts.

Verification
REQ-035 disp_req held 1, disp_addr 0,1,2,3 on consecutive cycles, memory pattern 1,0,1,1 -> disp_valid high 4 consecutive cycles starting 3 cycles after first accept, disp_data 1,0,1,1.
REQ-036 disp_req and in_req held 1, MAX_WAIT=4 -> display granted 4 cycles, input granted 5th, wait_cnt back to 0, display resumes; disp_stall pulses once.
REQ-037 in_req only, in_addr=0x07A, mem[0x07A]=1 -> in_grant same cycle, mem_en with mem_addr 0x07A next cycle, in_valid=1, in_data=1 three cycles after accept, disp_valid stays 0.
REQ-038 gen_busy=1 with both requests high for 6 cycles -> no grants, mem_en 0, wait_cnt holds, disp_stall high each following cycle; gen_busy=0 -> arbitration resumes per REQ-024.
REQ-039 Two transfers accepted, reset pulsed low one cycle later -> all outputs 0 immediately, no valid pulse after release, new request served with 3-cycle latency.
